// File: rtl/rv32_ifetch_queue_if.sv
// Signal bundle between the prefetch queue, instruction memory and the decoder.
// The queue side is 'master'; the memory/decoder environment is 'slave'.
interface rv32_ifetch_queue_if;
    logic [31:0] iaddress;
    logic        iread;
    logic        iwaitrequest;
    logic [31:0] ireaddata;
    logic        ireaddatavalid;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_err;

    modport master (
        output iaddress, iread, instr, instr_pc, instr_valid, fetch_err,
        input  iwaitrequest, ireaddata, ireaddatavalid, flush, flush_pc, instr_ready
    );

    modport slave (
        input  iaddress, iread, instr, instr_pc, instr_valid, fetch_err,
        output iwaitrequest, ireaddata, ireaddatavalid, flush, flush_pc, instr_ready
    );
endinterface

// File: rtl/rv32_ifetch_queue.sv
// RV32 instruction prefetch queue: issues pipelined reads ahead of the decoder,
// buffers {instr, pc} and discards stale responses after a PC redirect.
module rv32_ifetch_queue #(
    parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
    parameter int          LOG2_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    rv32_ifetch_queue_if.master  bus
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int CW    = LOG2_DEPTH + 1;

    typedef logic [CW-1:0]         cnt_t;
    typedef logic [LOG2_DEPTH-1:0] ptr_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
    localparam cnt_t MAX_C   = cnt_t'(MAX_OUTSTANDING);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] resp_pc_q,  resp_pc_d;
    logic [31:0] pend_pc_q,  pend_pc_d;
    cnt_t        count_q,    count_d;
    cnt_t        out_q,      out_d;
    cnt_t        drop_q,     drop_d;
    ptr_t        rd_ptr_q,   rd_ptr_d;
    ptr_t        wr_ptr_q,   wr_ptr_d;
    logic        pend_q,     pend_d;
    logic        held_q;
    logic        err_q;

    logic [31:0] data_q [DEPTH];
    logic [31:0] pc_q   [DEPTH];

    logic [CW:0] credit;
    logic        iread, accept, stall, rsp, stray, drop_rsp, push, pop;
    logic [31:0] flush_tgt;

    assign flush_tgt = {bus.flush_pc[31:2], 2'b00};
    assign credit    = {1'b0, count_q} + {1'b0, out_q};

    // A stalled request stays asserted regardless of credit or pending redirect.
    assign iread    = ~reset & (held_q | ((credit < {1'b0, DEPTH_C}) & (out_q < MAX_C) & ~pend_q));
    assign accept   = iread & ~bus.iwaitrequest;
    assign stall    = iread &  bus.iwaitrequest;
    assign rsp      = bus.ireaddatavalid & (out_q != '0);
    assign stray    = bus.ireaddatavalid & (out_q == '0);
    assign drop_rsp = rsp & (drop_q != '0);
    assign push     = rsp & ~drop_rsp & ~bus.flush;
    assign pop      = (count_q != '0) & bus.instr_ready & ~bus.flush;
    assign out_d    = out_q + cnt_t'(accept) - cnt_t'(rsp);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        pend_pc_d  = pend_pc_q;
        pend_d     = pend_q;
        drop_d     = drop_q - cnt_t'(drop_rsp);
        count_d    = count_q + cnt_t'(push) - cnt_t'(pop);
        rd_ptr_d   = rd_ptr_q + ptr_t'(pop);
        wr_ptr_d   = wr_ptr_q + ptr_t'(push);

        if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
        if (push)   resp_pc_d  = resp_pc_q + 32'd4;

        // The request that was stuck across a redirect carries stale data.
        if (pend_q & accept) begin
            drop_d     = drop_d + cnt_t'(1);
            fetch_pc_d = pend_pc_q;
            pend_d     = 1'b0;
        end

        if (bus.flush) begin
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            resp_pc_d = flush_tgt;
            drop_d    = out_d;
            if (stall) begin
                pend_d     = 1'b1;
                pend_pc_d  = flush_tgt;
                fetch_pc_d = fetch_pc_q;
            end else begin
                pend_d     = 1'b0;
                fetch_pc_d = flush_tgt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_VECTOR;
            resp_pc_q  <= RESET_VECTOR;
            pend_pc_q  <= RESET_VECTOR;
            count_q    <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            pend_q     <= 1'b0;
            held_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            pend_pc_q  <= pend_pc_d;
            count_q    <= count_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            pend_q     <= pend_d;
            held_q     <= stall;
            err_q      <= err_q | stray;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= bus.ireaddata;
            pc_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

    assign bus.iaddress    = fetch_pc_q;
    assign bus.iread       = iread;
    assign bus.instr       = data_q[rd_ptr_q];
    assign bus.instr_pc    = pc_q[rd_ptr_q];
    assign bus.instr_valid = (count_q != '0);
    assign bus.fetch_err   = err_q;
endmodule

// File: tb/tb_rv32_ifetch_queue.sv
// Directed bench for rv32_ifetch_queue: streaming and back-pressure with an
// automatic 1-cycle slave, then a cycle-exact vector table for flush corners.
module tb_rv32_ifetch_queue;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rv32_ifetch_queue_if bus();

    rv32_ifetch_queue #(
        .RESET_VECTOR(32'h0000_0000),
        .LOG2_DEPTH(2),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h5EED_C0DE;
    endfunction

    // Manual drive vs. automatic zero-wait, latency-1 slave
    logic        auto;
    logic        m_wait, m_vld, fl, rdy;
    logic [31:0] m_data, fpc;
    logic        a_vld;
    logic [31:0] a_data;

    always @(posedge clk) begin
        a_vld  <= auto & ~reset & bus.iread & ~bus.iwaitrequest;
        a_data <= mdata(bus.iaddress);
    end

    assign bus.iwaitrequest   = auto ? 1'b0   : m_wait;
    assign bus.ireaddatavalid = auto ? a_vld  : m_vld;
    assign bus.ireaddata      = auto ? a_data : m_data;
    assign bus.flush          = fl;
    assign bus.flush_pc       = fpc;
    assign bus.instr_ready    = rdy;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic        wt, rv;
        logic [31:0] raddr;
        logic        fl;
        logic [31:0] fpc;
        logic        rdy;
        logic        e_rd;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(input logic wt, input logic rv, input logic [31:0] raddr,
                                input logic f, input logic [31:0] fp, input logic r,
                                input logic e_rd, input logic [31:0] e_addr,
                                input logic e_vld, input logic [31:0] e_pc, input logic e_err);
        vec_t v;
        v.wt = wt; v.rv = rv; v.raddr = raddr; v.fl = f; v.fpc = fp; v.rdy = r;
        v.e_rd = e_rd; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc; v.e_err = e_err;
        return v;
    endfunction

    vec_t tv [22];

    initial begin
        int          acc, pops;
        logic [31:0] exp_pc;
        bit          found;

        //         wt rv raddr     fl fpc       rdy rd addr      vld pc        err
        tv[0]  = mk(0, 0, 32'h000, 0, 32'h000, 0,  1, 32'h000, 0, 32'h000, 0);
        tv[1]  = mk(0, 0, 32'h000, 0, 32'h000, 0,  1, 32'h004, 0, 32'h000, 0);
        tv[2]  = mk(0, 1, 32'h000, 0, 32'h000, 0,  0, 32'h008, 0, 32'h000, 0);
        tv[3]  = mk(0, 1, 32'h004, 0, 32'h000, 0,  1, 32'h008, 1, 32'h000, 0);
        tv[4]  = mk(0, 0, 32'h000, 0, 32'h000, 0,  1, 32'h00C, 1, 32'h000, 0);
        tv[5]  = mk(0, 0, 32'h000, 1, 32'h100, 1,  0, 32'h010, 1, 32'h000, 0);
        tv[6]  = mk(0, 1, 32'h008, 0, 32'h000, 0,  0, 32'h100, 0, 32'h000, 0);
        tv[7]  = mk(0, 1, 32'h00C, 0, 32'h000, 0,  1, 32'h100, 0, 32'h000, 0);
        tv[8]  = mk(1, 1, 32'h100, 0, 32'h000, 0,  1, 32'h104, 0, 32'h000, 0);
        tv[9]  = mk(1, 0, 32'h000, 1, 32'h203, 1,  1, 32'h104, 1, 32'h100, 0);
        tv[10] = mk(1, 0, 32'h000, 0, 32'h000, 0,  1, 32'h104, 0, 32'h000, 0);
        tv[11] = mk(0, 0, 32'h000, 0, 32'h000, 0,  1, 32'h104, 0, 32'h000, 0);
        tv[12] = mk(1, 1, 32'h104, 0, 32'h000, 0,  1, 32'h200, 0, 32'h000, 0);
        tv[13] = mk(0, 0, 32'h000, 0, 32'h000, 0,  1, 32'h200, 0, 32'h000, 0);
        tv[14] = mk(0, 1, 32'h200, 0, 32'h000, 0,  1, 32'h204, 0, 32'h000, 0);
        tv[15] = mk(0, 1, 32'h204, 1, 32'h300, 1,  1, 32'h208, 1, 32'h200, 0);
        tv[16] = mk(1, 1, 32'h208, 0, 32'h000, 0,  1, 32'h300, 0, 32'h000, 0);
        tv[17] = mk(0, 0, 32'h000, 0, 32'h000, 0,  1, 32'h300, 0, 32'h000, 0);
        tv[18] = mk(1, 1, 32'h300, 0, 32'h000, 0,  1, 32'h304, 0, 32'h000, 0);
        tv[19] = mk(1, 1, 32'hBAD0, 0, 32'h000, 1, 1, 32'h304, 1, 32'h300, 0);
        tv[20] = mk(0, 0, 32'h000, 0, 32'h000, 0,  1, 32'h304, 0, 32'h000, 1);
        tv[21] = mk(1, 0, 32'h000, 0, 32'h000, 0,  1, 32'h308, 0, 32'h000, 1);

        reset = 1'b1; auto = 1'b0; m_wait = 1'b0; m_vld = 1'b0; m_data = '0;
        fl = 1'b0; fpc = '0; rdy = 1'b0;

        // Reset state and first request
        do_reset();
        #1;
        chk("rst_iread",  {31'b0, bus.iread},       32'd1);
        chk("rst_iaddr",  bus.iaddress,             32'h0);
        chk("rst_valid",  {31'b0, bus.instr_valid}, 32'd0);
        chk("rst_err",    {31'b0, bus.fetch_err},   32'd0);

        // Streaming: one instruction per cycle once the pipe fills
        auto = 1'b1; rdy = 1'b1;
        do_reset();
        exp_pc = 32'h0; pops = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk($sformatf("stream_vld%0d", k), {31'b0, bus.instr_valid}, {31'b0, k >= 2});
            if (bus.instr_valid) begin
                chk($sformatf("stream_pc%0d", k),   bus.instr_pc, exp_pc);
                chk($sformatf("stream_data%0d", k), bus.instr,    mdata(exp_pc));
                exp_pc += 32'd4;
                pops++;
            end
            @(negedge clk);
        end
        chk("stream_pops", pops, 10);

        // Back-pressure: exactly DEPTH reads, then resume at 0x10 after a pop
        rdy = 1'b0;
        do_reset();
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (bus.iread) begin
                chk($sformatf("bp_addr%0d", acc), bus.iaddress, 32'(acc * 4));
                acc++;
            end
            @(negedge clk);
        end
        #1;
        chk("bp_accepts", acc, 4);
        chk("bp_iread0",  {31'b0, bus.iread},       32'd0);
        chk("bp_head_pc", bus.instr_pc,             32'h0);
        chk("bp_valid",   {31'b0, bus.instr_valid}, 32'd1);
        rdy = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clk); #1;
            if (bus.iread) begin
                found = 1'b1;
                chk("bp_resume_addr", bus.iaddress, 32'h10);
            end
        end
        if (!found) begin
            total++; bad++;
            $display("FAIL bp_resume timeout act=no_read exp=read_at_00000010");
        end

        // Cycle-exact flush corner table
        auto = 1'b0; rdy = 1'b0;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            m_wait = tv[i].wt; m_vld = tv[i].rv; m_data = mdata(tv[i].raddr);
            fl = tv[i].fl; fpc = tv[i].fpc; rdy = tv[i].rdy;
            #1;
            chk($sformatf("tv%0d_iread", i), {31'b0, bus.iread},       {31'b0, tv[i].e_rd});
            chk($sformatf("tv%0d_iaddr", i), bus.iaddress,             tv[i].e_addr);
            chk($sformatf("tv%0d_valid", i), {31'b0, bus.instr_valid}, {31'b0, tv[i].e_vld});
            chk($sformatf("tv%0d_err", i),   {31'b0, bus.fetch_err},   {31'b0, tv[i].e_err});
            if (tv[i].e_vld) begin
                chk($sformatf("tv%0d_pc", i),    bus.instr_pc, tv[i].e_pc);
                chk($sformatf("tv%0d_instr", i), bus.instr,    mdata(tv[i].e_pc));
            end
            @(negedge clk);
        end
        m_wait = 1'b0; m_vld = 1'b0; fl = 1'b0; rdy = 1'b0;

        // Reset mid-operation clears sticky error and in-flight state
        reset = 1'b1;
        #1;
        chk("mid_rst_iread", {31'b0, bus.iread}, 32'd0);
        @(negedge clk); #1;
        chk("mid_rst_err",   {31'b0, bus.fetch_err},   32'd0);
        chk("mid_rst_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("mid_rst_iaddr", bus.iaddress,             32'h0);
        reset = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
